// File: rtl/user_obi_rr_arbiter.sv
// Round-robin arbiter that lets several OBI managers share one OBI subordinate.
// An in-order FIFO of grant winners steers each response back to the manager that issued the request.
module user_obi_rr_arbiter #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumMgr-1:0]             mgr_req_i,
  output logic [NumMgr-1:0]             mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]             mgr_we_i,
  input  logic [NumMgr*IdWidth-1:0]     mgr_aid_i,
  output logic [NumMgr-1:0]             mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [IdWidth-1:0]            mgr_rid_o,
  output logic                          sbr_req_o,
  input  logic                          sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [IdWidth-1:0]            sbr_aid_o,
  input  logic                          sbr_rvalid_i,
  input  logic [DataWidth-1:0]          sbr_rdata_i,
  input  logic                          sbr_err_i,
  input  logic [IdWidth-1:0]            sbr_rid_i,
  output logic                          spurious_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] head;
  logic [IdxW-1:0] fifo_mem [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            any_req;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after the priority pointer, wrapping mod NumMgr.
  always_comb begin : arbitrate
    int   cand;
    logic found;
    cand   = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < int'(NumMgr); i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= int'(NumMgr)) cand = cand - int'(NumMgr);
      if (!found && mgr_req_i[cand]) begin
        winner = IdxW'(cand);
        found  = 1'b1;
      end
    end
  end

  assign any_req    = |mgr_req_i;
  assign full       = (count_q == CntW'(MaxTrans));
  assign empty      = (count_q == '0);
  assign sbr_req_o  = any_req & ~full;
  assign push       = sbr_req_o & sbr_gnt_i;
  assign pop        = sbr_rvalid_i & ~empty;
  assign spurious_o = sbr_rvalid_i & empty;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    sbr_addr_o   = '0;
    sbr_we_o     = 1'b0;
    sbr_aid_o    = '0;
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    mgr_rdata_o  = '0;
    mgr_err_o    = 1'b0;
    mgr_rid_o    = '0;
    if (sbr_req_o) begin
      sbr_addr_o        = mgr_addr_i[int'(winner)*int'(AddrWidth) +: AddrWidth];
      sbr_we_o          = mgr_we_i[winner];
      sbr_aid_o         = mgr_aid_i[int'(winner)*int'(IdWidth) +: IdWidth];
      mgr_gnt_o[winner] = sbr_gnt_i;
    end
    if (pop) begin
      mgr_rvalid_o[head] = 1'b1;
      mgr_rdata_o        = sbr_rdata_i;
      mgr_err_o          = sbr_err_i;
      mgr_rid_o          = sbr_rid_i;
    end
  end

  // Storage only: validity is tracked by count_q, so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= winner;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wrap_inc(wr_ptr_q);
        rr_ptr_q <= (winner == IdxW'(NumMgr - 1)) ? '0 : winner + 1'b1;
      end
      if (pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(mgr_gnt_o));
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(mgr_rvalid_o));

endmodule

// File: tb/tb_user_obi_rr_arbiter.sv
// Directed bench for user_obi_rr_arbiter: a latency-programmable ROM-like subordinate
// plus a scoreboard of expected grants and routed responses.
module tb_user_obi_rr_arbiter;

  localparam int NM = 2;
  localparam int MT = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   mgr_req;
  logic [NM-1:0]   mgr_gnt;
  logic [NM*AW-1:0] mgr_addr;
  logic [NM-1:0]   mgr_we;
  logic [NM*IW-1:0] mgr_aid;
  logic [NM-1:0]   mgr_rvalid;
  logic [DW-1:0]   mgr_rdata;
  logic            mgr_err;
  logic [IW-1:0]   mgr_rid;
  logic            sbr_req;
  logic            sbr_gnt;
  logic [AW-1:0]   sbr_addr;
  logic            sbr_we;
  logic [IW-1:0]   sbr_aid;
  logic            sbr_rvalid;
  logic [DW-1:0]   sbr_rdata;
  logic            sbr_err;
  logic [IW-1:0]   sbr_rid;
  logic            spurious;

  always #5 clk = ~clk;

  user_obi_rr_arbiter #(
    .NumMgr(NM), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mgr_req_i(mgr_req), .mgr_gnt_o(mgr_gnt), .mgr_addr_i(mgr_addr),
    .mgr_we_i(mgr_we), .mgr_aid_i(mgr_aid),
    .mgr_rvalid_o(mgr_rvalid), .mgr_rdata_o(mgr_rdata), .mgr_err_o(mgr_err), .mgr_rid_o(mgr_rid),
    .sbr_req_o(sbr_req), .sbr_gnt_i(sbr_gnt), .sbr_addr_o(sbr_addr), .sbr_we_o(sbr_we),
    .sbr_aid_o(sbr_aid), .sbr_rvalid_i(sbr_rvalid), .sbr_rdata_i(sbr_rdata),
    .sbr_err_i(sbr_err), .sbr_rid_i(sbr_rid), .spurious_o(spurious)
  );

  typedef struct {
    int            mgr;
    logic [DW-1:0] data;
    logic          err;
    logic [IW-1:0] rid;
  } rsp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
    logic [IW-1:0] rid;
  } pend_t;

  rsp_t          exp_q[$];
  pend_t         pend_q[$];
  logic [NM-1:0] gnt_hist[$];
  logic [NM-1:0] alt [4];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int mptr = 0;
  int lat = 1;
  int n_gnt = 0;
  int n_spur = 0;
  logic chk_en = 1'b0;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return 32'h4B757368 + a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check settled outputs at negedge against the model,
  // then act as the subordinate just after the following posedge.
  task automatic cycle();
    logic          ereq;
    logic [NM-1:0] egnt;
    logic [NM-1:0] erv;
    int            w;
    rsp_t          r;
    pend_t         p;
    @(negedge clk);
    if (chk_en) begin
      ereq = (|mgr_req) && (exp_q.size() < MT);
      w    = -1;
      egnt = '0;
      if (ereq) begin
        for (int i = 0; i < NM; i++) begin
          int c;
          c = (mptr + i) % NM;
          if (w < 0 && mgr_req[c]) w = c;
        end
        if (sbr_gnt) egnt[w] = 1'b1;
      end
      chk("sbr_req", sbr_req, ereq);
      chk("mgr_gnt", mgr_gnt, egnt);
      if (ereq) begin
        chk("sbr_addr", sbr_addr, mgr_addr[w*AW +: AW]);
        chk("sbr_we", sbr_we, mgr_we[w]);
        chk("sbr_aid", sbr_aid, mgr_aid[w*IW +: IW]);
      end
      chk("spurious", spurious, sbr_rvalid && (exp_q.size() == 0));
      if (spurious) n_spur++;
      if (sbr_rvalid && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        erv = '0;
        erv[r.mgr] = 1'b1;
        chk("mgr_rvalid", mgr_rvalid, erv);
        chk("mgr_rdata", mgr_rdata, r.data);
        chk("mgr_err", mgr_err, r.err);
        chk("mgr_rid", mgr_rid, r.rid);
      end else begin
        chk("mgr_rvalid_idle", mgr_rvalid, 0);
        chk("mgr_rdata_idle", mgr_rdata, 0);
        chk("mgr_err_idle", mgr_err, 0);
        chk("mgr_rid_idle", mgr_rid, 0);
      end
      if (ereq && sbr_gnt) begin
        exp_q.push_back('{w, rom(mgr_addr[w*AW +: AW]), mgr_we[w], mgr_aid[w*IW +: IW]});
        mptr = (w + 1) % NM;
        n_gnt++;
      end
      gnt_hist.push_back(mgr_gnt);
    end
    if (sbr_req && sbr_gnt)
      pend_q.push_back('{cyc + lat, rom(sbr_addr), sbr_we, sbr_aid});
    @(posedge clk);
    cyc++;
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      sbr_rvalid = 1'b1;
      sbr_rdata  = p.data;
      sbr_err    = p.err;
      sbr_rid    = p.rid;
    end else begin
      sbr_rvalid = 1'b0;
      sbr_rdata  = '0;
      sbr_err    = 1'b0;
      sbr_rid    = '0;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mgr_req = '0;
    chk_en  = 1'b0;
    cycle();
    rst    = 1'b0;
    chk_en = 1'b1;
    mptr   = 0;
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    mgr_req    = '0;
    mgr_we     = '0;
    mgr_addr   = {32'h0000_0100, 32'h0000_0000};
    mgr_aid    = 2'b10;
    sbr_gnt    = 1'b1;
    sbr_rvalid = 1'b0;
    sbr_rdata  = '0;
    sbr_err    = 1'b0;
    sbr_rid    = '0;
    alt = '{2'b01, 2'b10, 2'b01, 2'b10};

    // Reset, then idle: every output must read zero.
    cycle();
    do_reset();
    repeat (2) cycle();

    // Single read from mgr0, response one cycle later.
    mgr_req = 2'b01;
    cycle();
    mgr_req = 2'b00;
    cycle();
    chk("t1_grants", n_gnt, 1);

    // Both managers requesting continuously from reset.
    do_reset();
    gnt_hist.delete();
    mgr_req = 2'b11;
    repeat (4) cycle();
    mgr_req = 2'b00;
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) chk("t2_alternate", gnt_hist[i], alt[i]);
    chk("t2_drained", exp_q.size(), 0);

    // Four-cycle response latency: FIFO fills, grant resumes after the first pop.
    lat = 4;
    n_gnt = 0;
    mgr_req = 2'b11;
    repeat (5) cycle();
    chk("t3_full_two_gnts", n_gnt, 2);
    cycle();
    chk("t3_gnt_after_pop", n_gnt, 3);
    mgr_req = 2'b00;
    repeat (8) cycle();
    lat = 1;

    // Response with nothing outstanding.
    pend_q.push_back('{cyc + 1, 32'hDEAD_BEEF, 1'b1, 1'b1});
    cycle();
    cycle();
    chk("t4_spurious_count", n_spur, 1);

    // Write from mgr1 answered with an error.
    mgr_we  = 2'b10;
    mgr_req = 2'b10;
    cycle();
    mgr_req = 2'b00;
    repeat (2) cycle();
    mgr_we = 2'b00;

    // Reset with two outstanding; late responses must be spurious and the pointer back at 0.
    lat = 4;
    mgr_req = 2'b10;
    cycle();
    mgr_req = 2'b01;
    cycle();
    do_reset();
    repeat (4) cycle();
    chk("t6_late_spurious", n_spur, 3);
    mgr_req = 2'b11;
    cycle();
    chk("t6_ptr_after_reset", gnt_hist[$], 2'b01);
    mgr_req = 2'b00;
    repeat (6) cycle();
    chk("end_scoreboard_empty", exp_q.size(), 0);
    chk("end_sub_idle", pend_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
